// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, requester IDs and FSM encoding for the memory port arbiter
package mem_pkg;

    localparam int ARCH_BITS   = 32;
    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = 4;

    localparam logic [ARCH_BITS-1:0] LINE_MASK = ~ARCH_BITS'((1 << OFFSET_BITS) - 1);

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_I = 2'd0;
    localparam req_id_t REQ_D = 2'd1;
    localparam req_id_t REQ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic same_line(input logic [ARCH_BITS-1:0] a, input logic [ARCH_BITS-1:0] b);
        return ((a ^ b) & LINE_MASK) == '0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if;
    import mem_pkg::*;

    logic                 i_req;
    logic [ARCH_BITS-1:0] i_addr;
    logic [LINE_BITS-1:0] i_line;
    logic                 i_valid;

    logic                 d_req;
    logic [ARCH_BITS-1:0] d_addr;
    logic [LINE_BITS-1:0] d_line;
    logic                 d_valid;

    logic                 w_req;
    logic [ARCH_BITS-1:0] w_addr;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_ack;

    logic                 mem_req;
    logic                 mem_we;
    logic [ARCH_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_wline;
    logic [LINE_BITS-1:0] mem_rline;
    logic                 mem_done;

    logic                 busy;

    modport master (
        input  i_req, i_addr, d_req, d_addr, w_req, w_addr, w_line, mem_rline, mem_done,
        output i_line, i_valid, d_line, d_valid, w_ack,
        output mem_req, mem_we, mem_addr, mem_wline, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr, w_req, w_addr, w_line, mem_rline, mem_done,
        input  i_line, i_valid, d_line, d_valid, w_ack,
        input  mem_req, mem_we, mem_addr, mem_wline, busy
    );

endinterface

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational 3-way round-robin picker with a force-W override
module rr_pick3
    import mem_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_t    last,
    input  logic       force_w,
    output req_id_t    winner,
    output logic       valid
);

    always_comb begin
        winner = REQ_I;
        valid  = |req;
        if (force_w) begin
            winner = REQ_W;
        end else begin
            case (last)
                REQ_I:   winner = req[1] ? REQ_D : (req[2] ? REQ_W : REQ_I);
                REQ_D:   winner = req[2] ? REQ_W : (req[0] ? REQ_I : REQ_D);
                default: winner = req[0] ? REQ_I : (req[1] ? REQ_D : REQ_W);
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises icache, dcache and writeback line transfers onto one memory port
module mem_port_arbiter
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_port_arbiter_if.master bus
);

    state_t               state;
    req_id_t              owner;
    req_id_t              last;
    req_id_t              winner;
    logic                 win_valid;
    logic                 force_w;
    logic [ARCH_BITS-1:0] sel_addr;

    // A writeback to the line a dcache miss wants must land first, or the fill returns stale data.
    assign force_w = bus.d_req & bus.w_req & same_line(bus.d_addr, bus.w_addr);

    rr_pick3 u_pick (
        .req     ({bus.w_req, bus.d_req, bus.i_req}),
        .last    (last),
        .force_w (force_w),
        .winner  (winner),
        .valid   (win_valid)
    );

    always_comb begin
        sel_addr = bus.i_addr;
        case (winner)
            REQ_D:   sel_addr = bus.d_addr;
            REQ_W:   sel_addr = bus.w_addr;
            default: sel_addr = bus.i_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= REQ_I;
            last          <= REQ_W;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wline <= '0;
            bus.i_line    <= '0;
            bus.d_line    <= '0;
            bus.i_valid   <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.w_ack     <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.i_valid <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.w_ack   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        owner        <= winner;
                        last         <= winner;
                        bus.mem_we   <= (winner == REQ_W);
                        bus.mem_addr <= sel_addr & LINE_MASK;
                        if (winner == REQ_W) begin
                            bus.mem_wline <= bus.w_line;
                        end
                        bus.mem_req  <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_done) begin
                        bus.mem_req <= 1'b0;
                        state       <= ST_RESP;
                        // The pulse is suppressed when the owner has abandoned its request.
                        case (owner)
                            REQ_I: begin
                                bus.i_line  <= bus.mem_rline;
                                bus.i_valid <= bus.i_req;
                            end
                            REQ_D: begin
                                bus.d_line  <= bus.mem_rline;
                                bus.d_valid <= bus.d_req;
                            end
                            default: bus.w_ack <= bus.w_req;
                        endcase
                    end
                end
                ST_RESP: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.mem_req <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk;
    logic rst;
    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // transaction-level reference state: 0 idle, 1 transfer outstanding, 2 response cycle
    int           m_phase;
    int           m_last;
    int           m_owner;
    logic [127:0] m_iline;
    logic [127:0] m_dline;
    int           grants[$];

    logic         p_rst;
    logic         p_req[3];
    logic [31:0]  p_addr[3];
    logic [127:0] p_wline;
    logic         p_done;
    logic [127:0] p_rline;

    int  fixed_lat = -1;
    bit  spurious_en = 0;
    bit  auto_en = 0;
    bit  mm_active = 0;
    int  mm_cnt = 0;
    int  req_high_cnt = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic int pick();
        if (p_req[1] && p_req[2] && ((p_addr[1] >> 4) == (p_addr[2] >> 4))) return 2;
        for (int k = 1; k <= 3; k++) begin
            int id;
            id = (m_last + k) % 3;
            if (p_req[id]) return id;
        end
        return 0;
    endfunction

    task automatic model_check();
        logic [2:0] obs_p;
        logic [2:0] exp_p;
        int w;
        obs_p = {bus.w_ack, bus.d_valid, bus.i_valid};
        exp_p = 3'b000;
        if (p_rst) begin
            m_phase = 0;
            m_last  = 2;
            m_iline = '0;
            m_dline = '0;
            check_eq("rst_ctl", {bus.mem_req, bus.busy, bus.mem_we}, 3'b000);
            check_eq("rst_addr", bus.mem_addr, 0);
            check_eq("rst_wline", bus.mem_wline, 0);
        end else begin
            case (m_phase)
                0: begin
                    if (p_req[0] || p_req[1] || p_req[2]) begin
                        w = pick();
                        check_eq("grant_ctl", {bus.mem_req, bus.busy}, 2'b11);
                        check_eq("grant_we", bus.mem_we, (w == 2));
                        check_eq("grant_addr", bus.mem_addr, p_addr[w] & 32'hFFFF_FFF0);
                        if (w == 2) check_eq("grant_wline", bus.mem_wline, p_wline);
                        m_owner = w;
                        m_last  = w;
                        grants.push_back(w);
                        m_phase = 1;
                    end else begin
                        check_eq("idle_ctl", {bus.mem_req, bus.busy}, 2'b00);
                    end
                end
                1: begin
                    if (p_done) begin
                        check_eq("resp_ctl", {bus.mem_req, bus.busy}, 2'b01);
                        if (m_owner == 0) m_iline = p_rline;
                        else if (m_owner == 1) m_dline = p_rline;
                        if (p_req[m_owner]) exp_p = 3'(1 << m_owner);
                        m_phase = 2;
                    end else begin
                        check_eq("busy_ctl", {bus.mem_req, bus.busy}, 2'b11);
                    end
                end
                default: begin
                    check_eq("ret_ctl", {bus.mem_req, bus.busy}, 2'b00);
                    m_phase = 0;
                end
            endcase
        end
        check_eq("pulses", obs_p, exp_p);
        check_eq("i_line", bus.i_line, m_iline);
        check_eq("d_line", bus.d_line, m_dline);
    endtask

    task automatic mem_drive();
        bus.mem_done = 1'b0;
        if (bus.mem_req) begin
            req_high_cnt++;
            if (!mm_active) begin
                mm_active = 1;
                mm_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (mm_cnt == 0) begin
                bus.mem_done  = 1'b1;
                bus.mem_rline = {$urandom, $urandom, $urandom, $urandom};
                mm_active = 0;
            end else begin
                mm_cnt--;
            end
        end else begin
            mm_active = 0;
            if (spurious_en && $urandom_range(0, 5) == 0) begin
                bus.mem_done  = 1'b1;
                bus.mem_rline = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFF_FF00);
        return a;
    endfunction

    task automatic gen_stim();
        logic [2:0] pulse;
        pulse = {bus.w_ack, bus.d_valid, bus.i_valid};
        if (bus.i_req) begin
            if ((pulse[0] && $urandom_range(0, 3) != 0) || $urandom_range(0, 49) == 0) bus.i_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            bus.i_addr = rand_addr();
            bus.i_req  = 1'b1;
        end
        if (bus.d_req) begin
            if ((pulse[1] && $urandom_range(0, 3) != 0) || $urandom_range(0, 49) == 0) bus.d_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            bus.d_addr = rand_addr();
            bus.d_req  = 1'b1;
        end
        if (bus.w_req) begin
            if (pulse[2] && $urandom_range(0, 3) != 0) bus.w_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            bus.w_addr = rand_addr();
            bus.w_line = {$urandom, $urandom, $urandom, $urandom};
            bus.w_req  = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        p_rst     = rst;
        p_req[0]  = bus.i_req;
        p_req[1]  = bus.d_req;
        p_req[2]  = bus.w_req;
        p_addr[0] = bus.i_addr;
        p_addr[1] = bus.d_addr;
        p_addr[2] = bus.w_addr;
        p_wline   = bus.w_line;
        p_done    = bus.mem_done;
        p_rline   = bus.mem_rline;
        @(negedge clk);
        model_check();
        mem_drive();
        if (auto_en) gen_stim();
    endtask

    task automatic wait_pulse(input int which, input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if ({bus.w_ack, bus.d_valid, bus.i_valid} & 3'(1 << which)) seen = 1;
        end
        if (!seen) check_eq(tag, 0, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && bus.busy; n++) step();
        step();
    endtask

    task automatic wait_grants(input int cnt, input string tag);
        for (int n = 0; n < 60 && grants.size() < cnt; n++) step();
        if (grants.size() < cnt) check_eq(tag, grants.size(), cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = 0; bus.d_req = 0; bus.w_req = 0;
        bus.i_addr = 0; bus.d_addr = 0; bus.w_addr = 0; bus.w_line = 0;
        bus.mem_done = 0; bus.mem_rline = 0;
        m_phase = 0; m_last = 2; m_owner = 0; m_iline = 0; m_dline = 0;
        do_reset();
        step();

        // icache miss with two cycles of memory latency
        fixed_lat = 2;
        bus.i_addr = 32'h0000_1234;
        bus.i_req = 1'b1;
        req_high_cnt = 0;
        wait_pulse(0, "t1_timeout");
        check_eq("t1_req_cycles", req_high_cnt, 3);
        bus.i_req = 1'b0;
        wait_idle();

        // all three held high: fair rotation from reset
        do_reset();
        fixed_lat = 0;
        grants.delete();
        bus.i_addr = 32'h100; bus.d_addr = 32'h200; bus.w_addr = 32'h300;
        bus.w_line = {4{32'hA5A5_0001}};
        bus.i_req = 1; bus.d_req = 1; bus.w_req = 1;
        wait_grants(4, "t2_timeout");
        if (grants.size() >= 4) begin
            check_eq("t2_g0", grants[0], 0);
            check_eq("t2_g1", grants[1], 1);
            check_eq("t2_g2", grants[2], 2);
            check_eq("t2_g3", grants[3], 0);
        end
        bus.i_req = 0; bus.d_req = 0; bus.w_req = 0;
        wait_idle();

        // same-line writeback beats a dcache miss the pointer favours
        bus.i_addr = 32'h500; bus.i_req = 1;
        wait_pulse(0, "t3_i_timeout");
        bus.i_req = 0;
        wait_idle();
        grants.delete();
        bus.d_addr = 32'h40; bus.w_addr = 32'h4C;
        bus.w_line = {$urandom, $urandom, $urandom, $urandom};
        bus.d_req = 1; bus.w_req = 1;
        for (int n = 0; n < 40 && (bus.d_req || bus.w_req); n++) begin
            step();
            if (bus.w_ack) bus.w_req = 0;
            if (bus.d_valid) bus.d_req = 0;
        end
        check_eq("t3_drained", {bus.d_req, bus.w_req}, 2'b00);
        if (grants.size() >= 2) begin
            check_eq("t3_first_w", grants[0], 2);
            check_eq("t3_then_d", grants[1], 1);
        end else check_eq("t3_grants", grants.size(), 2);
        wait_idle();

        // dcache abandons its miss mid-transfer
        fixed_lat = 3;
        bus.d_addr = 32'h80; bus.d_req = 1;
        for (int n = 0; n < 10 && !bus.mem_req; n++) step();
        bus.d_req = 0;
        for (int n = 0; n < 8; n++) step();
        bus.i_addr = 32'h904; bus.i_req = 1;
        wait_pulse(0, "t4_timeout");
        bus.i_req = 0;
        wait_idle();

        // reset while a transfer is outstanding
        fixed_lat = 6;
        bus.i_addr = 32'h700; bus.i_req = 1;
        for (int n = 0; n < 10 && !bus.mem_req; n++) step();
        step();
        rst = 1; bus.i_req = 0;
        step();
        rst = 0;
        grants.delete();
        fixed_lat = 1;
        bus.i_addr = 32'h110; bus.d_addr = 32'h220; bus.w_addr = 32'h330;
        bus.i_req = 1; bus.d_req = 1; bus.w_req = 1;
        wait_grants(1, "t5_timeout");
        if (grants.size() >= 1) check_eq("t5_first_i", grants[0], 0);
        bus.i_req = 0; bus.d_req = 0; bus.w_req = 0;
        wait_idle();

        // stray completions while idle
        spurious_en = 1;
        for (int n = 0; n < 12; n++) step();

        fixed_lat = -1;
        auto_en = 1;
        for (int n = 0; n < 3000; n++) step();
        auto_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
